// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package regfile_arb_pkg;

  typedef enum logic {ARB, CLEAR} arb_state_t;

  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_NUM_REGS = 8;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus and register-file write port of the arbiter.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      clear_start;
  logic                      clear_busy;
  logic                      rf_write;
  logic [ADDR_W-1:0]         rf_addr;
  logic [DATA_W-1:0]         rf_data;
  logic [1:0]                grant_id;

  modport master (
    output req_valid, req_addr, req_data, clear_start,
    input  req_ready, clear_busy, rf_write, rf_addr, rf_data, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, clear_start,
    output req_ready, clear_busy, rf_write, rf_addr, rf_data, grant_id
  );
endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after i_ptr wins.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W  = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(i_ptr) + k) % NUM_REQ;
      if (i_en && !w_found && i_req[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = PTR_W'(j);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among requesters and sequences a
// one-register-per-cycle clear sweep.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_write_arbiter_if.slave   bus
);

  localparam int PTR_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(NUM_REGS);

  arb_state_t        r_state, w_state_next;
  logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_rf_write, w_rf_write_next;
  logic [ADDR_W-1:0] r_rf_addr, w_rf_addr_next;
  logic [DATA_W-1:0] r_rf_data, w_rf_data_next;
  logic [1:0]        r_grant_id, w_grant_id_next;

  logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0] w_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]  w_idx;
  logic              w_arb_en;
  logic              w_any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign w_data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A clear request or reset blocks every grant in the same cycle.
  assign w_arb_en = reset && (r_state == ARB) && !bus.clear_start;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_any          = |w_grant;
  assign bus.req_ready  = w_grant;
  assign bus.clear_busy = (r_state == CLEAR);
  assign bus.rf_write   = r_rf_write;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.rf_data    = r_rf_data;
  assign bus.grant_id   = r_grant_id;

  always_comb begin
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_cnt_next      = r_cnt;
    w_rf_write_next = 1'b0;
    w_rf_addr_next  = r_rf_addr;
    w_rf_data_next  = r_rf_data;
    w_grant_id_next = r_grant_id;
    case (r_state)
      ARB: begin
        if (bus.clear_start) begin
          w_state_next = CLEAR;
          w_cnt_next   = '0;
        end else if (w_any) begin
          w_rf_write_next = 1'b1;
          w_rf_addr_next  = w_addr_arr[w_idx];
          w_rf_data_next  = w_data_arr[w_idx];
          w_grant_id_next = 2'(w_idx);
          w_rr_ptr_next   = PTR_W'((int'(w_idx) + 1) % NUM_REQ);
        end
      end
      CLEAR: begin
        w_rf_write_next = 1'b1;
        w_rf_addr_next  = ADDR_W'(r_cnt);
        w_rf_data_next  = '0;
        w_grant_id_next = 2'd0;
        if (r_cnt == CNT_W'(NUM_REGS - 1)) begin
          w_state_next = ARB;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_rf_write <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
      r_grant_id <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_cnt      <= w_cnt_next;
      r_rf_write <= w_rf_write_next;
      r_rf_addr  <= w_rf_addr_next;
      r_rf_data  <= w_rf_data_next;
      r_grant_id <= w_grant_id_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter with a write scoreboard and a
// register-file model fed from the rf_* outputs.
module tb_regfile_write_arbiter;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic [1:0] gid;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  logic [7:0] rf_model [8];

  regfile_write_arbiter_if #(.NUM_REQ(3), .DATA_W(8), .ADDR_W(3)) bus ();

  regfile_write_arbiter #(.NUM_REQ(3), .DATA_W(8), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rf_write === 1'b1) rf_model[bus.rf_addr] <= bus.rf_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [7:0] d);
    bus.req_valid[i]       = v;
    bus.req_addr[i*3 +: 3] = a;
    bus.req_data[i*8 +: 8] = d;
  endtask

  task automatic push_exp(input int g);
    exp_t e;
    e.addr = bus.req_addr[g*3 +: 3];
    e.data = bus.req_data[g*8 +: 8];
    e.gid  = 2'(g);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid   = 3'b111;
    set_req(0, 1'b1, 3'd1, 8'h01);
    set_req(1, 1'b1, 3'd2, 8'h02);
    set_req(2, 1'b1, 3'd3, 8'h03);
    bus.clear_start = 1'b1;
    reset           = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      #2;
      n_cmp++;
      if (bus.req_ready !== 3'b000 || bus.rf_write !== 1'b0 || bus.rf_addr !== 3'd0 ||
          bus.rf_data !== 8'h00 || bus.clear_busy !== 1'b0 || bus.grant_id !== 2'd0) begin
        n_err++;
        $display("FAIL reset_state: ready=%b wr=%b addr=%0d data=%h busy=%b gid=%0d, required all zero",
                 bus.req_ready, bus.rf_write, bus.rf_addr, bus.rf_data, bus.clear_busy, bus.grant_id);
      end
    end
    bus.clear_start = 1'b0;
    reset           = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL reset_first_grant: ready=%b required 001", bus.req_ready);
    end
    push_exp(0);
    tick();
    begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (bus.rf_write !== 1'b1 || bus.rf_addr !== e.addr || bus.rf_data !== e.data || bus.grant_id !== e.gid) begin
        n_err++;
        $display("FAIL reset_first_write: wr=%b addr=%0d data=%h gid=%0d required 1 %0d %h %0d",
                 bus.rf_write, bus.rf_addr, bus.rf_data, bus.grant_id, e.addr, e.data, e.gid);
      end
    end
    bus.req_valid = 3'b000;
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    set_req(1, 1'b1, 3'd5, 8'hA7);
    #2;
    n_cmp++;
    if (bus.req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL single_ready: ready=%b required 010", bus.req_ready);
    end
    push_exp(1);
    tick();
    bus.req_valid = 3'b000;
    begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (bus.rf_write !== 1'b1 || bus.rf_addr !== 3'd5 || bus.rf_data !== 8'hA7 || bus.grant_id !== 2'd1 ||
          bus.rf_addr !== e.addr || bus.rf_data !== e.data || bus.grant_id !== e.gid) begin
        n_err++;
        $display("FAIL single_write: wr=%b addr=%0d data=%h gid=%0d required 1 5 a7 1",
                 bus.rf_write, bus.rf_addr, bus.rf_data, bus.grant_id);
      end
    end
    tick();
    n_cmp++;
    if (bus.rf_write !== 1'b0 || bus.rf_addr !== 3'd5) begin
      n_err++;
      $display("FAIL single_idle: wr=%b addr=%0d required 0 5(held)", bus.rf_write, bus.rf_addr);
    end
    $display("test_single_write done");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 3'(i + 1), 8'(8'h10 + 8'(i)));
    for (int k = 0; k < 6; k++) begin
      logic [2:0] exp_rdy;
      exp_rdy = 3'b001 << (k % 3);
      #2;
      n_cmp++;
      if (bus.req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rr_ready[%0d]: ready=%b required %b", k, bus.req_ready, exp_rdy);
      end
      push_exp(k % 3);
      tick();
      begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (bus.rf_write !== 1'b1 || bus.rf_data !== e.data || bus.rf_addr !== e.addr || bus.grant_id !== e.gid) begin
          n_err++;
          $display("FAIL rr_write[%0d]: wr=%b addr=%0d data=%h gid=%0d required 1 %0d %h %0d",
                   k, bus.rf_write, bus.rf_addr, bus.rf_data, bus.grant_id, e.addr, e.data, e.gid);
        end
      end
    end
    bus.req_valid = 3'b000;
    $display("test_round_robin done");
  endtask

  task automatic test_clear_sweep();
    set_req(2, 1'b1, 3'd6, 8'h5C);
    bus.clear_start = 1'b1;
    #2;
    n_cmp++;
    if (bus.req_ready !== 3'b000) begin
      n_err++;
      $display("FAIL clear_pulse_ready: ready=%b required 000", bus.req_ready);
    end
    tick();
    bus.clear_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #2;
      n_cmp++;
      if (bus.clear_busy !== 1'b1 || bus.req_ready !== 3'b000 ||
          bus.rf_write !== (c > 0) || (c > 0 && (bus.rf_addr !== 3'(c - 1) || bus.rf_data !== 8'h00))) begin
        n_err++;
        $display("FAIL clear_cycle[%0d]: busy=%b ready=%b wr=%b addr=%0d data=%h",
                 c, bus.clear_busy, bus.req_ready, bus.rf_write, bus.rf_addr, bus.rf_data);
      end
      tick();
    end
    #2;
    n_cmp++;
    if (bus.clear_busy !== 1'b0 || bus.rf_write !== 1'b1 || bus.rf_addr !== 3'd7 ||
        bus.rf_data !== 8'h00 || bus.req_ready !== 3'b100) begin
      n_err++;
      $display("FAIL clear_end: busy=%b wr=%b addr=%0d data=%h ready=%b required 0 1 7 00 100",
               bus.clear_busy, bus.rf_write, bus.rf_addr, bus.rf_data, bus.req_ready);
    end
    push_exp(2);
    tick();
    bus.req_valid = 3'b000;
    begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (bus.rf_write !== 1'b1 || bus.rf_addr !== e.addr || bus.rf_data !== e.data || bus.grant_id !== e.gid) begin
        n_err++;
        $display("FAIL clear_after_grant: wr=%b addr=%0d data=%h gid=%0d required 1 %0d %h %0d",
                 bus.rf_write, bus.rf_addr, bus.rf_data, bus.grant_id, e.addr, e.data, e.gid);
      end
    end
    for (int a = 0; a < 8; a++) begin
      n_cmp++;
      if (rf_model[a] !== 8'h00) begin
        n_err++;
        $display("FAIL clear_rf[%0d]: value=%h required 00", a, rf_model[a]);
      end
    end
    $display("test_clear_sweep done");
  endtask

  task automatic test_clear_ignored();
    int busy_cnt;
    busy_cnt = 0;
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) bus.clear_start = 1'b1;
      #2;
      if (bus.clear_busy === 1'b1) busy_cnt++;
      tick();
      bus.clear_start = 1'b0;
    end
    n_cmp++;
    if (busy_cnt !== 8) begin
      n_err++;
      $display("FAIL clear_ignored: busy cycles=%0d required 8", busy_cnt);
    end
    $display("test_clear_ignored done");
  endtask

  task automatic test_clear_abort();
    for (int j = 0; j < 4; j++) begin
      set_req(0, 1'b1, 3'(4 + j), 8'(8'hC0 + 8'(j)));
      #2;
      n_cmp++;
      if (bus.req_ready !== 3'b001) begin
        n_err++;
        $display("FAIL abort_fill_ready[%0d]: ready=%b required 001", j, bus.req_ready);
      end
      push_exp(0);
      tick();
      begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (bus.rf_write !== 1'b1 || bus.rf_addr !== e.addr || bus.rf_data !== e.data) begin
          n_err++;
          $display("FAIL abort_fill[%0d]: wr=%b addr=%0d data=%h required 1 %0d %h",
                   j, bus.rf_write, bus.rf_addr, bus.rf_data, e.addr, e.data);
        end
      end
    end
    bus.req_valid   = 3'b000;
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b0;
    tick();
    #2;
    n_cmp++;
    if (bus.rf_write !== 1'b0 || bus.clear_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_outputs: wr=%b busy=%b required 0 0", bus.rf_write, bus.clear_busy);
    end
    reset = 1'b1;
    for (int a = 0; a < 8; a++) begin
      logic [7:0] exp_v;
      exp_v = (a < 4) ? 8'h00 : 8'(8'hC0 + 8'(a - 4));
      n_cmp++;
      if (rf_model[a] !== exp_v) begin
        n_err++;
        $display("FAIL abort_rf[%0d]: value=%h required %h", a, rf_model[a], exp_v);
      end
    end
    $display("test_clear_abort done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 1'b1, 3'd3, 8'h11);
    set_req(1, 1'b1, 3'd3, 8'h22);
    for (int k = 0; k < 2; k++) begin
      logic [2:0] exp_rdy;
      exp_rdy = 3'b001 << k;
      #2;
      n_cmp++;
      if (bus.req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL b2b_ready[%0d]: ready=%b required %b", k, bus.req_ready, exp_rdy);
      end
      push_exp(k);
      tick();
      bus.req_valid[k] = 1'b0;
      begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (bus.rf_write !== 1'b1 || bus.rf_addr !== 3'd3 || bus.rf_data !== e.data) begin
          n_err++;
          $display("FAIL b2b_write[%0d]: wr=%b addr=%0d data=%h required 1 3 %h",
                   k, bus.rf_write, bus.rf_addr, bus.rf_data, e.data);
        end
      end
    end
    tick();
    n_cmp++;
    if (rf_model[3] !== 8'h22) begin
      n_err++;
      $display("FAIL b2b_last_wins: rf[3]=%h required 22", rf_model[3]);
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    reset           = 1'b0;
    bus.req_valid   = 3'b000;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.clear_start = 1'b0;
    for (int a = 0; a < 8; a++) rf_model[a] = 8'hEE;
    @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_sweep();
    test_clear_ignored();
    test_clear_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
